// File: rtl/char_buf_reader.sv
// Streams a length-prefixed string from a synchronous RAM onto an AXI-Stream master port.
// Define CHAR_BUF_READER_LEN_CLAMP_EN to clamp the stored length to STRLENDATA_SAVED_ADDR.
`timescale 1ns/1ps
module char_buf_reader #(
  parameter int STRLENDATA_SAVED_ADDR  = 100,
  parameter int CHAR_BUFFER_ADDR_WIDTH = 12
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic [CHAR_BUFFER_ADDR_WIDTH-1:0] ram_addr,
  output logic                              ram_ren,
  input  logic [7:0]                        ram_dout,
  output logic [7:0]                        m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [15:0]                       m_axis_tsize
);

  localparam int W = CHAR_BUFFER_ADDR_WIDTH;
  localparam logic [W-1:0] LP_LEN_HI_ADDR = W'(STRLENDATA_SAVED_ADDR);
  localparam logic [W-1:0] LP_LEN_LO_ADDR = W'(STRLENDATA_SAVED_ADDR + 1);

  typedef enum logic [1:0] {S_IDLE, S_RD_LEN, S_STREAM, S_DONE} state_t;

  state_t         r_state;
  logic [1:0]     r_len_step;
  logic [7:0]     r_len_hi;
  logic [15:0]    r_remaining;
  logic [W-1:0]   r_next_addr;
  logic           r_busy;
  logic           r_done;
  logic [W-1:0]   r_ram_addr;
  logic           r_ram_ren;
  logic [15:0]    r_tsize;
  logic           r_ren_stream;
  logic           r_ren_last;
  logic           r_arr_valid;
  logic           r_arr_last;
  logic [7:0]     r_buf0_data;
  logic [7:0]     r_buf1_data;
  logic           r_buf0_last;
  logic           r_buf1_last;
  logic [1:0]     r_occ;

  logic [15:0]    w_len_raw;
  logic [15:0]    w_len;
  logic           w_len_phase;
  logic [15:0]    w_rem_cur;
  logic [W-1:0]   w_addr_cur;
  logic           w_pop;
  logic [2:0]     w_occ_next;
  logic           w_issue;
  logic           w_issue_last;

  assign w_len_raw = {r_len_hi, ram_dout};

`ifdef CHAR_BUF_READER_LEN_CLAMP_EN
  localparam logic [15:0] LP_LEN_MAX = 16'(STRLENDATA_SAVED_ADDR);
  assign w_len = (w_len_raw > LP_LEN_MAX) ? LP_LEN_MAX : w_len_raw;
`else
  assign w_len = w_len_raw;
`endif

  // The first stream read is issued in the same cycle the low length byte arrives.
  assign w_len_phase  = (r_state == S_RD_LEN) && (r_len_step == 2'd2);
  assign w_rem_cur    = w_len_phase ? w_len : r_remaining;
  assign w_addr_cur   = w_len_phase ? '0 : r_next_addr;
  assign w_pop        = m_axis_tvalid && m_axis_tready;
  assign w_occ_next   = {1'b0, r_occ} + {2'b00, r_arr_valid} - {2'b00, w_pop};
  assign w_issue      = (w_len_phase || (r_state == S_STREAM)) && (w_rem_cur != 16'd0) &&
                        ((w_occ_next + {2'b00, r_ren_stream}) < 3'd2);
  assign w_issue_last = (w_rem_cur == 16'd1);

  // Arriving RAM data bypasses an empty buffer so the two-cycle read latency still allows one beat per clock.
  always_comb begin
    m_axis_tvalid = (r_occ != 2'd0) || r_arr_valid;
    m_axis_tdata  = 8'h00;
    m_axis_tlast  = 1'b0;
    if (r_occ != 2'd0) begin
      m_axis_tdata = r_buf0_data;
      m_axis_tlast = r_buf0_last;
    end else if (r_arr_valid) begin
      m_axis_tdata = ram_dout;
      m_axis_tlast = r_arr_last;
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign ram_addr     = r_ram_addr;
  assign ram_ren      = r_ram_ren;
  assign m_axis_tsize = r_tsize;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_len_step   <= 2'd0;
      r_len_hi     <= 8'h00;
      r_remaining  <= 16'd0;
      r_next_addr  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_ren    <= 1'b0;
      r_tsize      <= 16'd0;
      r_ren_stream <= 1'b0;
      r_ren_last   <= 1'b0;
      r_arr_valid  <= 1'b0;
      r_arr_last   <= 1'b0;
    end else begin
      r_ram_ren    <= 1'b0;
      r_ren_stream <= 1'b0;
      r_ren_last   <= 1'b0;
      r_arr_valid  <= r_ren_stream;
      r_arr_last   <= r_ren_last;
      if (w_issue) begin
        r_ram_ren    <= 1'b1;
        r_ram_addr   <= w_addr_cur;
        r_ren_stream <= 1'b1;
        r_ren_last   <= w_issue_last;
        r_next_addr  <= w_addr_cur + 1'b1;
        r_remaining  <= w_rem_cur - 16'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_RD_LEN;
            r_busy     <= 1'b1;
            r_len_step <= 2'd0;
            r_ram_ren  <= 1'b1;
            r_ram_addr <= LP_LEN_HI_ADDR;
          end
        end
        S_RD_LEN: begin
          case (r_len_step)
            2'd0: begin
              r_ram_ren  <= 1'b1;
              r_ram_addr <= LP_LEN_LO_ADDR;
              r_len_step <= 2'd1;
            end
            2'd1: begin
              r_len_hi   <= ram_dout;
              r_len_step <= 2'd2;
            end
            default: begin
              r_tsize    <= w_len;
              r_len_step <= 2'd0;
              if (w_len == 16'd0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_STREAM;
              end
            end
          endcase
        end
        S_STREAM: begin
          if (w_pop && m_axis_tlast) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Two-entry output buffer; entry 0 is the head presented on the stream port.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_occ       <= 2'd0;
      r_buf0_data <= 8'h00;
      r_buf1_data <= 8'h00;
      r_buf0_last <= 1'b0;
      r_buf1_last <= 1'b0;
    end else begin
      case (r_occ)
        2'd0: begin
          if (r_arr_valid && !w_pop) begin
            r_buf0_data <= ram_dout;
            r_buf0_last <= r_arr_last;
            r_occ       <= 2'd1;
          end
        end
        2'd1: begin
          if (w_pop && r_arr_valid) begin
            r_buf0_data <= ram_dout;
            r_buf0_last <= r_arr_last;
          end else if (w_pop) begin
            r_occ <= 2'd0;
          end else if (r_arr_valid) begin
            r_buf1_data <= ram_dout;
            r_buf1_last <= r_arr_last;
            r_occ       <= 2'd2;
          end
        end
        default: begin
          if (w_pop) begin
            r_buf0_data <= r_buf1_data;
            r_buf0_last <= r_buf1_last;
            if (r_arr_valid) begin
              r_buf1_data <= ram_dout;
              r_buf1_last <= r_arr_last;
            end else begin
              r_occ <= 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/char_buf_reader.md
CHAR_BUF_READER -- requirements
Module: char_buf_reader

Interface
REQ-001 SHALL have parameter STRLENDATA_SAVED_ADDR, default 100, RAM byte address of string length high byte; low byte at +1.
REQ-002 SHALL have parameter CHAR_BUFFER_ADDR_WIDTH, default 12, RAM address width W.
REQ-003 SHALL have port clk  input  1  the only clock; all logic on rising edge.
REQ-004 SHALL have port resetn  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port start  input  1  single-cycle request to stream the stored string.
REQ-006 SHALL have port busy  output  1  high from accepted start until the done cycle, inclusive.
REQ-007 SHALL have port done  output  1  one-cycle pulse when the transfer completes.
REQ-008 SHALL have port ram_addr  output  W  registered RAM read address.
REQ-009 SHALL have port ram_ren  output  1  registered RAM read enable.
REQ-010 SHALL have port ram_dout  input  8  RAM read data, valid exactly one cycle after the cycle presenting ram_ren=1.
REQ-011 SHALL have port m_axis_tdata  output  8  character byte.
REQ-012 SHALL have port m_axis_tvalid  output  1  beat valid.
REQ-013 SHALL have port m_axis_tready  input  1  sink ready.
REQ-014 SHALL have port m_axis_tlast  output  1  marks the final character.
REQ-015 SHALL have port m_axis_tsize  output  16  latched string length, held from length capture until the next accepted start.

Function
REQ-016 SHALL implement states IDLE, RD_LEN, STREAM, DONE.
REQ-017 IDLE: start=1 SHALL enter RD_LEN; start while not IDLE SHALL be ignored.
REQ-018 RD_LEN SHALL read STRLENDATA_SAVED_ADDR then STRLENDATA_SAVED_ADDR+1 on consecutive cycles and form length = {hi, lo} (big-endian).
REQ-019 After length capture, length 0 SHALL go directly to DONE with no beat emitted; otherwise SHALL enter STREAM.
REQ-020 STREAM SHALL read addresses 0..length-1 in order, each exactly once; beat k carries RAM[k].
REQ-021 Outputs SHALL be buffered in a 2-entry output buffer; a read SHALL be issued only when occupancy plus reads in flight is less than 2; no byte SHALL be dropped or duplicated.
REQ-022 With m_axis_tready held high, STREAM SHALL sustain one beat per clock; first tvalid SHALL occur no later than 6 cycles after the start cycle.
REQ-023 While m_axis_tvalid=1 and m_axis_tready=0, tdata and tlast SHALL hold stable and tvalid SHALL stay high.
REQ-024 m_axis_tlast SHALL be 1 only on beat length-1.
REQ-025 Acceptance of the tlast beat SHALL enter DONE; DONE SHALL assert done for one cycle, then return to IDLE.
REQ-026 The address counter SHALL be W bits; addresses wrap modulo 2^W (see REQ-031).
REQ-027 ram_ren SHALL be 0 whenever no read is being issued; ram_addr value is don't-care when ram_ren=0.

Reset
REQ-028 resetn=0 SHALL asynchronously force state IDLE and clear busy, done, ram_ren, ram_addr, m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tsize, buffer occupancy and in-flight count to 0.
REQ-029 Reset mid-transfer SHALL abort without emitting further beats; after release the block SHALL accept a new start normally.

Configuration
REQ-030 Macro CHAR_BUF_READER_LEN_CLAMP_EN SHALL select length clamping.
REQ-031 Defined: a captured length greater than STRLENDATA_SAVED_ADDR SHALL be clamped to STRLENDATA_SAVED_ADDR (m_axis_tsize reports the clamped value), so the length bytes are never streamed; undefined: length used unmodified, addresses wrap modulo 2^W.

Verification
REQ-032 RAM[100]=0x00, [101]=0x05, RAM[0..4]="HELLO", tready=1, start pulse -> 5 consecutive beats 'H','E','L','L','O', tlast on 'O', tsize=5, done one cycle after the 'O' acceptance cycle.
REQ-033 Same data, tready toggled 1,0,0,1,... -> identical byte sequence, tdata stable during stalls, no loss or duplication.
REQ-034 Length 0x0000 -> no tvalid, done pulse, busy low afterwards.
REQ-035 Length 0x00C8 (200): with CHAR_BUF_READER_LEN_CLAMP_EN -> 100 beats, tsize=100; without -> 200 beats reading addresses 0..199.
REQ-036 Second start during STREAM -> ignored, single transfer completes; resetn pulsed low at beat 2 -> tvalid drops immediately, next start streams full string from address 0.
